// File: rtl/sar_adc_pkg.sv
// Shared types and sizing helpers for the SAR ADC host-side sequencer.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    CONV = 2'd2,
    GAP  = 2'd3
  } sar_seq_state_t;

  // Bits needed for a down/up counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sar_out_buf.sv
// One-entry valid/ready holding register; a load into an unconsumed entry overwrites it
// and raises a sticky overrun flag (a new overrun beats a simultaneous clear).
module sar_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             ovr_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // A load on the acceptance cycle replaces the consumed entry without overrun.
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
    if (load_i && valid_q && !ready_i) begin
      overrun_d = 1'b1;
    end else if (ovr_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sar_adc_sequencer.sv
// Issues periodic start pulses to the SAR ADC, captures each result and streams it out.
// Define SAR_SEQ_AVG_EN to average 2**AVG_LOG2 conversions per output sample.
module sar_adc_sequencer
  import sar_adc_pkg::*;
#(
  parameter int ADC_WIDTH = 8,
  parameter int PERIOD    = 16,
  parameter int TIMEOUT   = 20,
  parameter int AVG_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 adc_start,
  input  logic                 adc_eoc,
  input  logic                 adc_den,
  input  logic [ADC_WIDTH-1:0] adc_dout,
  output logic [ADC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 ovr_clr,
  output logic                 timeout
);

`ifdef SAR_SEQ_AVG_EN
  localparam int AVG_ON = 1;
`else
  localparam int AVG_ON = 0;
`endif

  // Without averaging the shift collapses to 0: one capture per sample, no accumulation.
  localparam int AVG_SHIFT = AVG_ON * AVG_LOG2;
  localparam int ACC_W     = ADC_WIDTH + AVG_SHIFT;
  localparam int PCNT_W    = cnt_width(PERIOD - 1);
  localparam int TCNT_W    = cnt_width(TIMEOUT - 1);
  localparam int ACNT_W    = AVG_SHIFT + 1;

  localparam logic [PCNT_W-1:0] PERIOD_LOAD = PCNT_W'(PERIOD - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST    = TCNT_W'(TIMEOUT - 1);
  localparam logic [ACNT_W-1:0] AVG_LAST    = ACNT_W'((1 << AVG_SHIFT) - 1);

  sar_seq_state_t    state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACNT_W-1:0] avg_cnt_q, avg_cnt_d;

  logic [ACC_W-1:0]     acc_sum;
  logic                 avg_last;
  logic                 buf_load;
  logic [ADC_WIDTH-1:0] buf_data;

  assign acc_sum  = acc_q + ACC_W'(adc_dout);
  assign avg_last = (avg_cnt_q == AVG_LAST);
  assign buf_load = (state_q == CONV) && adc_den && avg_last;
  assign buf_data = acc_sum[ACC_W-1:AVG_SHIFT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      tcnt_q    <= '0;
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      tcnt_q    <= tcnt_d;
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pcnt_d    = (pcnt_q != '0) ? pcnt_q - PCNT_W'(1) : pcnt_q;
    tcnt_d    = tcnt_q;
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    adc_start = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && adc_eoc) state_d = TRIG;
      end
      TRIG: begin
        adc_start = 1'b1;
        pcnt_d    = PERIOD_LOAD;
        tcnt_d    = '0;
        state_d   = CONV;
      end
      CONV: begin
        if (adc_den) begin
          state_d = GAP;
          if (avg_last) begin
            acc_d     = '0;
            avg_cnt_d = '0;
          end else begin
            acc_d     = acc_sum;
            avg_cnt_d = avg_cnt_q + ACNT_W'(1);
          end
        end else if (tcnt_q == TMO_LAST) begin
          // Abandoned conversion: any partial average is discarded as well.
          timeout   = 1'b1;
          state_d   = GAP;
          acc_d     = '0;
          avg_cnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      GAP: begin
        // Leave when the counter hits 0 on this edge so start-to-start equals PERIOD.
        if (pcnt_q <= PCNT_W'(1)) begin
          state_d = (enable && adc_eoc) ? TRIG : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sar_out_buf #(
    .WIDTH(ADC_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (buf_load),
    .data_i   (buf_data),
    .ready_i  (out_ready),
    .ovr_clr_i(ovr_clr),
    .data_o   (out_data),
    .valid_o  (out_valid),
    .overrun_o(overrun)
  );

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Directed bench: sequencer driving a behavioural 8-bit SAR ADC with an ideal comparator.
// Build with SAR_SEQ_AVG_EN to run the averaging scenario instead of the streaming ones.
module tb_sar_adc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       adc_start;
  logic       adc_eoc;
  logic       adc_den;
  logic [7:0] adc_dout;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       ovr_clr;
  logic       timeout;

  logic [7:0] test_sig;
  logic       den_block;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         start_q[$];
  int         tmo_q[$];
  int         den_q[$];
  logic [7:0] got_q[$];
  logic       start_prev;
  logic       den_prev;

  sar_adc_sequencer #(
    .ADC_WIDTH(8),
    .PERIOD   (16),
    .TIMEOUT  (20),
    .AVG_LOG2 (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .adc_start(adc_start),
    .adc_eoc  (adc_eoc),
    .adc_den  (adc_den),
    .adc_dout (adc_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SAR ADC model: one bit trial per clock after start, den strobe 9 clocks after start.
  logic       m_busy;
  logic [7:0] m_mask;
  logic [7:0] m_res;
  logic       m_den;
  logic [7:0] m_trial;
  assign m_trial  = m_res | m_mask;
  assign adc_den  = m_den & ~den_block;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_mask   <= 8'h80;
      m_res    <= 8'h00;
      m_den    <= 1'b0;
      adc_dout <= 8'h00;
      adc_eoc  <= 1'b1;
    end else begin
      m_den <= 1'b0;
      if (!m_busy) begin
        if (adc_start) begin
          m_busy  <= 1'b1;
          m_mask  <= 8'h80;
          m_res   <= 8'h00;
          adc_eoc <= 1'b0;
        end
      end else begin
        m_res  <= (m_trial <= test_sig) ? m_trial : m_res;
        m_mask <= m_mask >> 1;
        if (m_mask == 8'h01) begin
          m_busy   <= 1'b0;
          m_den    <= 1'b1;
          adc_dout <= (m_trial <= test_sig) ? m_trial : m_res;
          adc_eoc  <= 1'b1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      start_prev <= 1'b0;
      den_prev   <= 1'b0;
    end else begin
      if (adc_start) begin
        check_eq("start_1cyc", {31'b0, start_prev}, 32'd0);
        start_q.push_back(cyc);
      end
      if (timeout) tmo_q.push_back(cyc);
      if (adc_den) den_q.push_back(cyc);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        $display("[TB] sample accepted data=%0d cyc=%0d", out_data, cyc);
      end
`ifndef SAR_SEQ_AVG_EN
      if (den_prev) check_eq("den_to_valid", {31'b0, out_valid}, 32'd1);
`endif
      start_prev <= adc_start;
      den_prev   <= adc_den;
    end
  end

  task automatic wait_start(output int c);
    int  base = start_q.size();
    bit  ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (start_q.size() > base) begin ok = 1'b1; break; end
    end
    check_eq("start_wait", {31'b0, ok}, 32'd1);
    c = ok ? start_q[base] : 0;
  endtask

  task automatic wait_tmo(output int c);
    int  base = tmo_q.size();
    bit  ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (tmo_q.size() > base) begin ok = 1'b1; break; end
    end
    check_eq("tmo_wait", {31'b0, ok}, 32'd1);
    c = ok ? tmo_q[base] : 0;
  endtask

  task automatic wait_den();
    int  base = den_q.size();
    bit  ok   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (den_q.size() > base) begin ok = 1'b1; break; end
    end
    check_eq("den_wait", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_sample(output logic [7:0] d);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() > 0) begin ok = 1'b1; break; end
      @(posedge clk);
    end
    check_eq("sample_wait", {31'b0, ok}, 32'd1);
    d = ok ? got_q.pop_front() : 8'hxx;
  endtask

  task automatic sync_sample();
    logic [7:0] d;
    got_q.delete();
    wait_sample(d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s0, s1, s2, m1, m2;
    int         nb;
    logic [7:0] d;

    rst_n     = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b1;
    ovr_clr   = 1'b0;
    den_block = 1'b0;
    test_sig  = 8'd153;

    repeat (3) @(negedge clk);
    check_eq("rst_start",   {31'b0, adc_start}, 32'd0);
    check_eq("rst_valid",   {31'b0, out_valid}, 32'd0);
    check_eq("rst_overrun", {31'b0, overrun},   32'd0);
    check_eq("rst_timeout", {31'b0, timeout},   32'd0);
    check_eq("rst_data",    {24'b0, out_data},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 enable = 1'b1;

`ifndef SAR_SEQ_AVG_EN
    // 1: steady stream of 153 at a 16-clock start period.
    for (int k = 0; k < 3; k++) begin
      wait_sample(d);
      check_eq("t1_data", {24'b0, d}, 32'd153);
    end
    check_eq("t1_period_a", start_q[1] - start_q[0], 32'd16);
    check_eq("t1_period_b", start_q[2] - start_q[1], 32'd16);
    check_eq("t1_overrun", {31'b0, overrun}, 32'd0);

    // 2: boundary codes.
    sync_sample(); #1 test_sig = 8'd0;
    wait_sample(d); check_eq("t2_zero", {24'b0, d}, 32'd0);
    #1 test_sig = 8'd255;
    wait_sample(d); check_eq("t2_full", {24'b0, d}, 32'd255);

    // 3: back-pressure, overwrite and overrun handling.
    sync_sample(); #1 out_ready = 1'b0; test_sig = 8'd10;
    wait_den(); #1 test_sig = 8'd20;
    wait_den(); #1 test_sig = 8'd30;
    wait_den();
    @(negedge clk);
    check_eq("t3_valid",   {31'b0, out_valid}, 32'd1);
    check_eq("t3_data",    {24'b0, out_data},  32'd30);
    check_eq("t3_overrun", {31'b0, overrun},   32'd1);
    check_eq("t3_no_accept", got_q.size(), 32'd0);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0; test_sig = 8'd40;
    @(negedge clk);
    check_eq("t3_ovr_clr", {31'b0, overrun},   32'd0);
    check_eq("t3_hold",    {24'b0, out_data},  32'd30);
    // Clear pulse coincides with a new overwrite: the set must win.
    wait_start(s0);
    repeat (8) @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0; test_sig = 8'd50;
    @(negedge clk);
    check_eq("t3_set_wins", {31'b0, overrun},  32'd1);
    check_eq("t3_data40",   {24'b0, out_data}, 32'd40);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    // Acceptance on the same cycle as a new load: no overrun.
    wait_start(s0);
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_same_ovr",  {31'b0, overrun},   32'd0);
    check_eq("t3_same_val",  {31'b0, out_valid}, 32'd1);
    wait_sample(d); check_eq("t3_old", {24'b0, d}, 32'd40);
    wait_sample(d); check_eq("t3_new", {24'b0, d}, 32'd50);
    check_eq("t3_no_tmo", tmo_q.size(), 32'd0);

    // 4: den withheld -> timeouts at start+20, start-to-start 22, then recovery.
    sync_sample(); #1 den_block = 1'b1; test_sig = 8'd200;
    wait_start(s1);
    wait_tmo(m1);
    check_eq("t4_tmo_delay_a", m1 - s1, 32'd20);
    check_eq("t4_valid_low", {31'b0, out_valid}, 32'd0);
    wait_start(s2);
    check_eq("t4_restart", s2 - s1, 32'd22);
    wait_tmo(m2);
    check_eq("t4_tmo_delay_b", m2 - s2, 32'd20);
    #1 den_block = 1'b0;
    check_eq("t4_no_output", got_q.size(), 32'd0);
    wait_sample(d); check_eq("t4_recover", {24'b0, d}, 32'd200);
    check_eq("t4_tmo_count", tmo_q.size(), 32'd2);

    // 5: enable dropped mid-conversion.
    sync_sample(); #1 test_sig = 8'd77;
    wait_start(s0);
    @(posedge clk); #1 enable = 1'b0;
    wait_sample(d); check_eq("t5_last", {24'b0, d}, 32'd77);
    nb = start_q.size();
    repeat (60) @(posedge clk);
    check_eq("t5_no_start", start_q.size(), nb);

    // Asynchronous reset in the middle of a conversion.
    #1 out_ready = 1'b0; test_sig = 8'd99; enable = 1'b1;
    wait_start(s0); wait_den();
    wait_start(s0); wait_den();
    wait_start(s0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("t5_pre_valid",   {31'b0, out_valid}, 32'd1);
    check_eq("t5_pre_data",    {24'b0, out_data},  32'd99);
    check_eq("t5_pre_overrun", {31'b0, overrun},   32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_start",   {31'b0, adc_start}, 32'd0);
    check_eq("t5_rst_valid",   {31'b0, out_valid}, 32'd0);
    check_eq("t5_rst_data",    {24'b0, out_data},  32'd0);
    check_eq("t5_rst_overrun", {31'b0, overrun},   32'd0);
    check_eq("t5_rst_timeout", {31'b0, timeout},   32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; enable = 1'b0;
`else
    // 6: averaging of four conversions: (100+101+102+104)>>2 = 101.
    test_sig = 8'd100;
    wait_den(); #1 test_sig = 8'd101;
    wait_den(); #1 test_sig = 8'd102;
    wait_den(); #1 test_sig = 8'd104;
    check_eq("t6_no_early", got_q.size(), 32'd0);
    wait_den();
    @(negedge clk);
    check_eq("t6_valid", {31'b0, out_valid}, 32'd1);
    check_eq("t6_data",  {24'b0, out_data},  32'd101);
    wait_sample(d); check_eq("t6_sample", {24'b0, d}, 32'd101);
    // A timeout discards two accumulated 200s; next four 40s average to 40.
    #1 test_sig = 8'd200;
    wait_den(); wait_den();
    #1 den_block = 1'b1;
    wait_tmo(m1);
    #1 den_block = 1'b0; test_sig = 8'd40;
    wait_den(); wait_den(); wait_den();
    check_eq("t6_no_partial", got_q.size(), 32'd0);
    wait_den();
    wait_sample(d); check_eq("t6_after_tmo", {24'b0, d}, 32'd40);
    check_eq("t6_overrun", {31'b0, overrun}, 32'd0);
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
